// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial-bus receive path: instruction codes,
// receiver state encoding and the lane-to-bit mapping helper.
package serial_bus_pkg;

  localparam logic [1:0] INSTR_READ = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HS = 2'd1,
    SHIFT   = 2'd2
  } rx_state_t;

  // Bit position inside the word that beat 'beat', lane 'lane' lands on.
  function automatic int lane_bit(input int beat, input int lane, input int word_size,
                                  input int lanes, input bit msb_first);
    return msb_first ? (word_size - lanes * (beat + 1) + lane) : (beat * lanes + lane);
  endfunction

endpackage

// File: rtl/master_rx_deser_if.sv
// Bundle of the slave-facing serial signals and the core-facing word port.
//
// Handshake rules:
//  - A word starts when slave_valid and master_ready are both high on a rising
//    edge; that edge samples beat 0. The remaining beats follow on consecutive
//    edges with no further handshake.
//  - new_rx is the valid of the word port and data is its payload. A word is
//    consumed on an edge where new_rx and data_ack are both high; data_ack
//    with new_rx low has no effect. data is stable while new_rx is high and
//    no ack is given.
interface master_rx_deser_if #(
  parameter int WORD_SIZE  = 8,
  parameter int LANES      = 1,
  parameter int BURST_SIZE = 12,
  parameter int FIFO_DEPTH = 4
);
  import serial_bus_pkg::*;

  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [1:0]            instruction;
  logic                  tx_done;
  logic [BURST_SIZE-1:0] burst_num;
  logic                  slave_valid;
  logic [LANES-1:0]      rx_data;
  logic                  master_ready;
  logic [WORD_SIZE-1:0]  data;
  logic                  new_rx;
  logic                  data_ack;
  logic                  rx_done;
  logic                  rx_timeout;
  logic [COUNT_W-1:0]    fifo_count;
  rx_state_t             rx_state;

  modport master (
    input  instruction, tx_done, burst_num, slave_valid, rx_data, data_ack,
    output master_ready, data, new_rx, rx_done, rx_timeout, fifo_count, rx_state
  );

  modport slave (
    output instruction, tx_done, burst_num, slave_valid, rx_data, data_ack,
    input  master_ready, data, new_rx, rx_done, rx_timeout, fifo_count, rx_state
  );

endinterface

// File: rtl/master_rx_deser_fifo.sv
// First-word-fall-through word FIFO. The head word is kept in a register so
// it is available one edge after a push into an empty FIFO and keeps its last
// value once the FIFO drains.
module rx_word_fifo #(
  parameter int WORD_SIZE  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic [WORD_SIZE-1:0]               push_data,
  input  logic                               pop,
  output logic [WORD_SIZE-1:0]               head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_next;
  logic [COUNT_W-1:0]   count_q, count_next;
  logic [WORD_SIZE-1:0] head_q, head_next;
  logic                 pop_ok;

  assign pop_ok = pop && (count_q != '0);
  assign head   = head_q;
  assign count  = count_q;

  // Next occupancy and next head word; a push into the slot that becomes the
  // head is forwarded directly since it is not in the array yet.
  always_comb begin
    count_next = count_q + COUNT_W'(push) - COUNT_W'(pop_ok);
    rd_next    = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
    head_next  = head_q;
    if (count_next != '0) begin
      head_next = (push && (wr_ptr == rd_next)) ? push_data : mem[rd_next];
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_next;
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

endmodule

// File: rtl/master_rx_deser.sv
// Serial-bus read receiver: after a READ command has gone out, assembles
// words from LANES serial lanes (one handshake per word) and queues them in a
// FWFT FIFO for the master core.
module master_rx_deser
  import serial_bus_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int LANES      = 1,
  parameter int BURST_SIZE = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 256,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  master_rx_deser_if.master   bus
);

  localparam int BEATS   = WORD_SIZE / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IDX_W   = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int COUNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (WORD_SIZE % LANES != 0) begin : g_bad_lanes
    $error("WORD_SIZE must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  rx_state_t              state;
  logic [BEAT_W-1:0]      beat;
  logic [BURST_SIZE-1:0]  words_left;
  logic [TIMER_W-1:0]     timer;
  logic [WORD_SIZE-1:0]   shift_q, word_asm;
  logic                   rx_done_q, rx_timeout_q;
  logic [COUNT_W-1:0]     fifo_count;
  logic                   handshake, last_beat;

  assign bus.master_ready = (state == WAIT_HS) && (fifo_count < COUNT_W'(FIFO_DEPTH));
  assign handshake        = (state == WAIT_HS) && bus.slave_valid && bus.master_ready;
  assign last_beat        = ((state == SHIFT) && (beat == LAST_BEAT)) ||
                            (handshake && (BEATS == 1));
  assign bus.new_rx       = (fifo_count != '0);
  assign bus.fifo_count   = fifo_count;
  assign bus.rx_done      = rx_done_q;
  assign bus.rx_timeout   = rx_timeout_q;
  assign bus.rx_state     = state;

  // Merge the current beat's lanes into the partially assembled word.
  // beat is 0 in WAIT_HS, so the handshake edge fills beat 0.
  always_comb begin
    word_asm = shift_q;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          word_asm[IDX_W'(lane_bit(b, l, WORD_SIZE, LANES, MSB_FIRST))] = bus.rx_data[l];
        end
      end
    end
  end

  // Receive FSM with its beat, word and handshake-timeout counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat         <= '0;
      words_left   <= '0;
      timer        <= '0;
      shift_q      <= '0;
      rx_done_q    <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      rx_done_q    <= 1'b0;
      rx_timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instruction == INSTR_READ && bus.tx_done) begin
            words_left <= bus.burst_num;
            beat       <= '0;
            timer      <= '0;
            state      <= WAIT_HS;
          end
        end
        WAIT_HS: begin
          if (handshake) begin
            shift_q <= word_asm;
            if (BEATS > 1) begin
              beat  <= 1'b1;
              state <= SHIFT;
            end
          end else if (TIMEOUT != 0) begin
            if (timer == TIMER_LAST) begin
              rx_timeout_q <= 1'b1;
              state        <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        SHIFT: begin
          shift_q <= word_asm;
          beat    <= beat + 1'b1;
        end
        default: state <= IDLE;
      endcase
      // Word completion overrides the per-state updates above.
      if (last_beat) begin
        beat  <= '0;
        timer <= '0;
        if (words_left == '0) begin
          rx_done_q <= 1'b1;
          state     <= IDLE;
        end else begin
          words_left <= words_left - 1'b1;
          state      <= WAIT_HS;
        end
      end
    end
  end

  rx_word_fifo #(
    .WORD_SIZE  (WORD_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (last_beat),
    .push_data (word_asm),
    .pop       (bus.new_rx && bus.data_ack),
    .head      (bus.data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_master_rx_deser.sv
// Bench for master_rx_deser: a 2-lane LSB-first instance (A) and a 1-lane
// MSB-first instance (B), each with a word-queue model of the expected FIFO
// contents built from the lane-to-bit rule.
module tb_master_rx_deser;
  import serial_bus_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] model_a[$];
  logic [7:0] model_b[$];

  master_rx_deser_if #(.WORD_SIZE(8), .LANES(2), .BURST_SIZE(12), .FIFO_DEPTH(4)) ia ();
  master_rx_deser_if #(.WORD_SIZE(8), .LANES(1), .BURST_SIZE(12), .FIFO_DEPTH(4)) ib ();

  master_rx_deser #(.WORD_SIZE(8), .LANES(2), .BURST_SIZE(12), .FIFO_DEPTH(4),
                    .TIMEOUT(16), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  master_rx_deser #(.WORD_SIZE(8), .LANES(1), .BURST_SIZE(12), .FIFO_DEPTH(4),
                    .TIMEOUT(16), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ib));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lanes of beat b for a 2-lane LSB-first word: lane l carries bit 2b+l.
  function automatic logic [1:0] lanes_a(input logic [7:0] w, input int b);
    logic [1:0] r;
    for (int l = 0; l < 2; l++) r[l] = w[2 * b + l];
    return r;
  endfunction

  task automatic start_read_a(input int burst);
    ia.instruction = INSTR_READ;
    ia.tx_done     = 1'b1;
    ia.burst_num   = 12'(burst);
    tick();
    ia.instruction = 2'b00;
    ia.tx_done     = 1'b0;
    check("a_state_wait", 32'(ia.rx_state), 32'(WAIT_HS));
  endtask

  task automatic start_read_b(input int burst);
    ib.instruction = INSTR_READ;
    ib.tx_done     = 1'b1;
    ib.burst_num   = 12'(burst);
    tick();
    ib.instruction = 2'b00;
    ib.tx_done     = 1'b0;
  endtask

  // Handshake and shift one word into A; returns after the edge that pushes it.
  task automatic send_a(input logic [7:0] w);
    int n = 0;
    while (ia.master_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("a_ready_hs", ia.master_ready, 1);
    ia.slave_valid = 1'b1;
    ia.rx_data     = lanes_a(w, 0);
    tick();
    ia.slave_valid = 1'b0;
    for (int b = 1; b < 4; b++) begin
      check("a_ready_shift", ia.master_ready, 0);
      ia.rx_data = lanes_a(w, b);
      if (b == 3) check("a_new_rx_pre", ia.new_rx, (model_a.size() != 0));
      tick();
    end
    model_a.push_back(w);
  endtask

  // Shift one word into B, MSB first; optionally ack the head on the last beat.
  task automatic send_b(input logic [7:0] w, input bit ack_last);
    int n = 0;
    while (ib.master_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("b_ready_hs", ib.master_ready, 1);
    ib.slave_valid = 1'b1;
    ib.rx_data     = w[7];
    tick();
    ib.slave_valid = 1'b0;
    for (int b = 1; b < 8; b++) begin
      ib.rx_data = w[7 - b];
      if (b == 7 && ack_last) ib.data_ack = 1'b1;
      tick();
    end
    ib.data_ack = 1'b0;
    if (ack_last && model_b.size() != 0) void'(model_b.pop_front());
    model_b.push_back(w);
  endtask

  task automatic pop_a();
    check("a_new_rx_pop", ia.new_rx, 1);
    if (model_a.size() != 0) check("a_data_order", ia.data, model_a[0]);
    ia.data_ack = 1'b1;
    tick();
    ia.data_ack = 1'b0;
    if (model_a.size() != 0) void'(model_a.pop_front());
    check("a_count_pop", ia.fifo_count, model_a.size());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ia.master_ready, 0);
    check({tag, "_data"}, ia.data, 0);
    check({tag, "_new_rx"}, ia.new_rx, 0);
    check({tag, "_count"}, ia.fifo_count, 0);
    check({tag, "_done"}, ia.rx_done, 0);
    check({tag, "_timeout"}, ia.rx_timeout, 0);
    check({tag, "_state"}, 32'(ia.rx_state), 32'(IDLE));
    check({tag, "_b_count"}, ib.fifo_count, 0);
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] last_popped;

    ia.instruction = '0; ia.tx_done = 0; ia.burst_num = '0;
    ia.slave_valid = 0; ia.rx_data = '0; ia.data_ack = 0;
    ib.instruction = '0; ib.tx_done = 0; ib.burst_num = '0;
    ib.slave_valid = 0; ib.rx_data = '0; ib.data_ack = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst0");
    tick();
    tick();
    @(negedge clk) reset = 1'b0;
    tick();

    // Single word: lanes 01,11,01,10 make 8'h9D
    start_read_a(0);
    check("a_ready_wait", ia.master_ready, 1);
    send_a(8'h9D);
    check("t1_new_rx", ia.new_rx, 1);
    check("t1_data", ia.data, 8'h9D);
    check("t1_count", ia.fifo_count, 1);
    check("t1_done", ia.rx_done, 1);
    check("t1_idle", 32'(ia.rx_state), 32'(IDLE));
    tick();
    check("t1_done_once", ia.rx_done, 0);
    pop_a();

    // Burst of three words in order; rx_done only after the last
    start_read_a(2);
    send_a(8'hA5);
    check("t2_done_w0", ia.rx_done, 0);
    send_a(8'h3C);
    check("t2_done_w1", ia.rx_done, 0);
    send_a(8'hF0);
    check("t2_done_w2", ia.rx_done, 1);
    check("t2_count", ia.fifo_count, 3);
    for (int i = 0; i < 3; i++) pop_a();

    // Backpressure: six random words with no ack until the FIFO is full
    start_read_a(5);
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom_range(0, 255));
      if (model_a.size() == 4) begin
        for (int k = 0; k < 3; k++) begin
          check("t3_ready_full", ia.master_ready, 0);
          check("t3_count_full", ia.fifo_count, 4);
          tick();
        end
        pop_a();
      end
      send_a(w);
      check("t3_done", ia.rx_done, (i == 5));
    end
    while (model_a.size() > 1) pop_a();
    last_popped = model_a[0];
    pop_a();
    ia.data_ack = 1'b1;
    tick();
    ia.data_ack = 1'b0;
    check("t3_ack_empty_count", ia.fifo_count, 0);
    check("t3_data_hold", ia.data, last_popped);

    // Timeout after one delivered word; the delivered word stays queued
    start_read_a(1);
    w = 8'($urandom_range(0, 255));
    send_a(w);
    for (int k = 0; k < 15; k++) begin
      check("t4_no_timeout", ia.rx_timeout, 0);
      tick();
    end
    check("t4_still_wait", 32'(ia.rx_state), 32'(WAIT_HS));
    tick();
    check("t4_timeout", ia.rx_timeout, 1);
    check("t4_idle", 32'(ia.rx_state), 32'(IDLE));
    check("t4_no_done", ia.rx_done, 0);
    check("t4_count", ia.fifo_count, 1);
    tick();
    check("t4_timeout_once", ia.rx_timeout, 0);
    pop_a();

    // Reset in the middle of a word at beat 2
    start_read_a(1);
    send_a(8'($urandom_range(0, 255)));
    w = 8'($urandom_range(0, 255));
    ia.slave_valid = 1'b1;
    ia.rx_data     = lanes_a(w, 0);
    tick();
    ia.slave_valid = 1'b0;
    ia.rx_data     = lanes_a(w, 1);
    tick();
    ia.rx_data     = lanes_a(w, 2);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5_rst");
    model_a.delete();
    model_b.delete();
    tick();
    check("t5_no_done", ia.rx_done, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    w = 8'($urandom_range(0, 255));
    start_read_a(0);
    send_a(w);
    check("t5_data", ia.data, w);
    check("t5_done", ia.rx_done, 1);
    pop_a();

    // MSB-first single lane: bits 1,0,1,0,0,1,0,1 give 8'hA5
    start_read_b(1);
    send_b(8'hA5, 1'b0);
    check("t6_data", ib.data, 8'hA5);
    check("t6_count", ib.fifo_count, 1);
    w = 8'($urandom_range(0, 255));
    send_b(w, 1'b1);
    check("t6_pushpop_count", ib.fifo_count, model_b.size());
    check("t6_pushpop_data", ib.data, model_b[0]);
    check("t6_done", ib.rx_done, 1);
    ib.data_ack = 1'b1;
    tick();
    ib.data_ack = 1'b0;
    check("t6_drained", ib.new_rx, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
